// File: rtl/cam_pixel_unpacker.sv
// cam_pixel_unpacker: turns the camera vsync/href/byte stream into pixels.
// Modes: 0 = Y from YUV422 (even bytes), 1 = two-byte pixels {first,second},
// 2/3 = every byte is a pixel. Tracks column/line and flags line/frame ends.
// Optional build macro CAM_LINE_CHECK_EN enables the per-line pixel count
// check against EXP_W; without it line_err is held at 0.
module cam_pixel_unpacker #(
    parameter int DW    = 8,
    parameter int CW    = 11,
    parameter int LW    = 10,
    parameter int EXP_W = 640
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              vsync,
    input  logic              href,
    input  logic              byte_en,
    input  logic [DW-1:0]     DATA_IN,
    input  logic [1:0]        mode,
    output logic              pix_valid,
    output logic [2*DW-1:0]   pix_data,
    output logic              sof,
    output logic [CW-1:0]     col_cnt,
    output logic [LW-1:0]     line_cnt,
    output logic              line_done,
    output logic              frame_done,
    output logic              odd_err,
    output logic              line_err
);

    // Expected line width must be representable in the column counter.
    if (EXP_W < 1 || EXP_W > (2**CW) - 1) begin : g_exp_w_range
        $error("EXP_W does not fit in CW bits");
    end

    typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              vsync_q, href_q, href_q2, byte_en_q;
    logic [DW-1:0]     data_q;
    logic [1:0]        mode_q, mode_d;
    logic              phase_q, phase_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     col_idx_q, col_idx_d;
    logic [LW-1:0]     line_idx_q, line_idx_d;
    logic              line_open_q, line_open_d;
    logic              lines_seen_q, lines_seen_d;
    logic              sof_pend_q, sof_pend_d;
    logic              frame_pend_q, frame_pend_d;
    logic              pix_valid_q, pix_valid_d;
    logic [2*DW-1:0]   pix_data_q, pix_data_d;
    logic              sof_q, sof_d;
    logic [CW-1:0]     col_out_q, col_out_d;
    logic [LW-1:0]     line_out_q, line_out_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              odd_err_q, odd_err_d;
    logic              line_err_q, line_err_d;

    logic              href_rise, href_fall, in_line, accept, close_line, cur_phase, emit;
    logic [2*DW-1:0]   emit_data;

    // State register plus one-stage input capture; reset wins over everything.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= WAIT_VS;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            href_q2      <= 1'b0;
            byte_en_q    <= 1'b0;
            data_q       <= '0;
            mode_q       <= 2'd0;
            phase_q      <= 1'b0;
            hold_q       <= '0;
            col_idx_q    <= '0;
            line_idx_q   <= '0;
            line_open_q  <= 1'b0;
            lines_seen_q <= 1'b0;
            sof_pend_q   <= 1'b0;
            frame_pend_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            sof_q        <= 1'b0;
            col_out_q    <= '0;
            line_out_q   <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            odd_err_q    <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            href_q       <= href;
            href_q2      <= href_q;
            byte_en_q    <= byte_en;
            data_q       <= DATA_IN;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            col_idx_q    <= col_idx_d;
            line_idx_q   <= line_idx_d;
            line_open_q  <= line_open_d;
            lines_seen_q <= lines_seen_d;
            sof_pend_q   <= sof_pend_d;
            frame_pend_q <= frame_pend_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            sof_q        <= sof_d;
            col_out_q    <= col_out_d;
            line_out_q   <= line_out_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            odd_err_q    <= odd_err_d;
            line_err_q   <= line_err_d;
        end
    end

    // Frame FSM, byte acceptance, pixel assembly and line/frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        col_idx_d    = col_idx_q;
        line_idx_d   = line_idx_q;
        line_open_d  = line_open_q;
        lines_seen_d = lines_seen_q;
        sof_pend_d   = sof_pend_q;
        frame_pend_d = 1'b0;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        sof_d        = 1'b0;
        col_out_d    = col_out_q;
        line_out_d   = line_out_q;
        line_done_d  = 1'b0;
        frame_done_d = frame_pend_q;
        odd_err_d    = 1'b0;
        line_err_d   = 1'b0;

        href_rise  = href_q & ~href_q2;
        href_fall  = ~href_q & href_q2;
        in_line    = (state_q == ACTIVE) && !vsync_q;
        accept     = in_line && href_q && byte_en_q;
        close_line = (state_q == ACTIVE) && line_open_q && (href_fall || vsync_q);
        // A byte arriving on the href rise cycle is phase 0 of the new line.
        cur_phase  = (in_line && href_rise) ? 1'b0 : phase_q;
        emit       = 1'b0;
        emit_data  = {{DW{1'b0}}, data_q};

        case (state_q)
            WAIT_VS: if (vsync_q) state_d = VBLANK;
            VBLANK: begin
                if (!vsync_q) begin
                    state_d      = ACTIVE;
                    mode_d       = mode;
                    line_idx_d   = '0;
                    lines_seen_d = 1'b0;
                    sof_pend_d   = 1'b1;
                    phase_d      = 1'b0;
                    col_idx_d    = '0;
                    line_open_d  = 1'b0;
                end
            end
            ACTIVE: begin
                if (vsync_q) begin
                    state_d = VBLANK;
                    // An open line closes first; frame_done follows one cycle later.
                    if (line_open_q)       frame_pend_d = 1'b1;
                    else if (lines_seen_q) frame_done_d = 1'b1;
                end
            end
            default: state_d = WAIT_VS;
        endcase

        if (in_line && href_rise) begin
            phase_d     = 1'b0;
            line_open_d = 1'b1;
        end

        if (accept) begin
            phase_d     = ~cur_phase;
            line_open_d = 1'b1;
            case (mode_q)
                2'd0: emit = ~cur_phase;
                2'd1: begin
                    if (!cur_phase) begin
                        hold_d = data_q;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {hold_q, data_q};
                    end
                end
                default: emit = 1'b1;
            endcase
        end

        if (emit) begin
            pix_valid_d = 1'b1;
            pix_data_d  = emit_data;
            sof_d       = sof_pend_q;
            sof_pend_d  = 1'b0;
            col_out_d   = col_idx_q;
            line_out_d  = line_idx_q;
            if (col_idx_q != {CW{1'b1}}) col_idx_d = col_idx_q + CW'(1);
        end

        if (close_line) begin
            line_done_d  = 1'b1;
            // A dangling half-pixel in Y or pair mode is dropped and flagged.
            odd_err_d    = (mode_q == 2'd0 || mode_q == 2'd1) && phase_q;
            phase_d      = 1'b0;
            col_idx_d    = '0;
            line_open_d  = 1'b0;
            lines_seen_d = 1'b1;
            if (line_idx_q != {LW{1'b1}}) line_idx_d = line_idx_q + LW'(1);
`ifdef CAM_LINE_CHECK_EN
            line_err_d   = (col_idx_q != CW'(EXP_W)) || (col_idx_q == {CW{1'b1}});
`endif
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign sof        = sof_q;
    assign col_cnt    = col_out_q;
    assign line_cnt   = line_out_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign odd_err    = odd_err_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_cam_pixel_unpacker.sv
// Directed bench for cam_pixel_unpacker: a negedge monitor logs pixels and
// line/frame pulses; each scenario drives a few lines and checks the log.
module tb_cam_pixel_unpacker;

    logic        HCLK = 1'b0;
    logic        HRESET, vsync, href, byte_en;
    logic [7:0]  DATA_IN;
    logic [1:0]  mode;
    logic        pix_valid, sof, line_done, frame_done, odd_err, line_err;
    logic [15:0] pix_data;
    logic [10:0] col_cnt;
    logic [9:0]  line_cnt;

    cam_pixel_unpacker #(.DW(8), .CW(11), .LW(10), .EXP_W(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .vsync(vsync), .href(href), .byte_en(byte_en),
        .DATA_IN(DATA_IN), .mode(mode), .pix_valid(pix_valid), .pix_data(pix_data),
        .sof(sof), .col_cnt(col_cnt), .line_cnt(line_cnt), .line_done(line_done),
        .frame_done(frame_done), .odd_err(odd_err), .line_err(line_err)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] px_data[$];
    logic [10:0] px_col[$];
    logic [9:0]  px_line[$];
    logic        px_sof[$];
    int          px_cyc[$];
    logic        ld_odd[$];
    logic        ld_lerr[$];
    int          ld_n, fd_n, ld_cyc, fd_cyc;
    int          first_cyc, fall_cyc, vs_cyc;
    logic [7:0]  lb[$];

    // Log every DUT event away from the active edge.
    always @(negedge HCLK) begin
        if (pix_valid) begin
            px_data.push_back(pix_data);
            px_col.push_back(col_cnt);
            px_line.push_back(line_cnt);
            px_sof.push_back(sof);
            px_cyc.push_back(cyc);
        end
        if (line_done) begin
            ld_n++;
            ld_cyc = cyc;
            ld_odd.push_back(odd_err);
            ld_lerr.push_back(line_err);
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic clear_mon();
        px_data.delete(); px_col.delete(); px_line.delete(); px_sof.delete(); px_cyc.delete();
        ld_odd.delete(); ld_lerr.delete();
        ld_n = 0; fd_n = 0; ld_cyc = -1; fd_cyc = -1;
    endtask

    // Drive lb[] as one line; optionally leave href high afterwards.
    task automatic send_line(input bit hold_href);
        for (int i = 0; i < lb.size(); i++) begin
            href = 1'b1; byte_en = 1'b1; DATA_IN = lb[i];
            if (i == 0) first_cyc = cyc;
            tick(1);
        end
        byte_en = 1'b0;
        if (!hold_href) begin
            href = 1'b0;
            fall_cyc = cyc;
            tick(4);
        end
    endtask

    // Vertical blanking pulse; mode is latched as vsync falls.
    task automatic new_frame(input logic [1:0] m);
        vsync = 1'b1; tick(3);
        mode = m;
        vsync = 1'b0; tick(3);
        clear_mon();
    endtask

    task automatic check_pix(input string tag, input int i, input logic [15:0] d,
                             input logic [10:0] c, input logic [9:0] l);
        check({tag, "_data"}, (i < px_data.size()) ? px_data[i] : 16'hxxxx, d);
        check({tag, "_col"},  (i < px_col.size())  ? px_col[i]  : 11'hxxx, c);
        check({tag, "_line"}, (i < px_line.size()) ? px_line[i] : 10'hxxx, l);
    endtask

    initial begin
        HRESET = 1'b1; vsync = 1'b0; href = 1'b0; byte_en = 1'b0; DATA_IN = 8'h00; mode = 2'd2;
        clear_mon();
        tick(3);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_sof", sof, 0);
        check("rst_col", col_cnt, 0);
        check("rst_line", line_cnt, 0);
        check("rst_pulses", {line_done, frame_done, odd_err, line_err}, 0);
        HRESET = 1'b0;
        $display("T1 reset mid-line");
        new_frame(2'd2);
        for (int i = 0; i < 10; i++) begin
            HRESET = (i == 5); href = 1'b1; byte_en = 1'b1; DATA_IN = 8'(8'h50 + i);
            tick(1);
        end
        HRESET = 1'b0; href = 1'b0; byte_en = 1'b0;
        tick(2);
        clear_mon();
        lb = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_line(1'b0);
        send_line(1'b0);
        check("t1_no_pix_before_vblank", px_data.size(), 0);
        check("t1_no_line_done", ld_n, 0);

        $display("T2 Y-only line");
        new_frame(2'd0);
        lb = '{8'h10, 8'h80, 8'h20, 8'h81, 8'h30, 8'h82, 8'h40, 8'h83};
        send_line(1'b0);
        check("t2_npix", px_data.size(), 4);
        check_pix("t2_p0", 0, 16'h0010, 0, 0);
        check_pix("t2_p1", 1, 16'h0020, 1, 0);
        check_pix("t2_p2", 2, 16'h0030, 2, 0);
        check_pix("t2_p3", 3, 16'h0040, 3, 0);
        check("t2_sof_first", (px_sof.size() > 0) ? px_sof[0] : 1'bx, 1);
        check("t2_sof_later", (px_sof.size() > 3) ? {px_sof[1], px_sof[2], px_sof[3]} : 3'bxxx, 0);
        check("t2_pix_latency", (px_cyc.size() > 0) ? px_cyc[0] - first_cyc : -1, 2);
        check("t2_line_done_n", ld_n, 1);
        check("t2_line_done_latency", ld_cyc - fall_cyc, 2);
        check("t2_odd_err", (ld_odd.size() > 0) ? ld_odd[0] : 1'bx, 0);

        $display("T3 pair mode odd byte");
        new_frame(2'd1);
        lb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        send_line(1'b0);
        check("t3_npix", px_data.size(), 2);
        check_pix("t3_p0", 0, 16'hA1B2, 0, 0);
        check_pix("t3_p1", 1, 16'hC3D4, 1, 0);
        check("t3_odd_err", (ld_odd.size() > 0) ? ld_odd[0] : 1'bx, 1);

        $display("T4 mode change mid-frame");
        new_frame(2'd2);
        lb = '{8'h11, 8'h22, 8'h33};
        send_line(1'b0);
        mode = 2'd1;
        lb = '{8'h44, 8'h55};
        send_line(1'b0);
        check("t4_npix", px_data.size(), 5);
        check_pix("t4_p2", 2, 16'h0033, 2, 0);
        check_pix("t4_p3", 3, 16'h0044, 0, 1);
        check_pix("t4_p4", 4, 16'h0055, 1, 1);
        check("t4_raw_no_odd", (ld_odd.size() > 1) ? {ld_odd[0], ld_odd[1]} : 2'bxx, 0);
        new_frame(2'd1);
        lb = '{8'h66, 8'h77};
        send_line(1'b0);
        check("t4_pair_npix", px_data.size(), 1);
        check_pix("t4_pair", 0, 16'h6677, 0, 0);

        $display("T5 three lines then frame end");
        new_frame(2'd0);
        lb = '{8'h01, 8'hF0, 8'h02, 8'hF1, 8'h03, 8'hF2, 8'h04, 8'hF3};
        for (int l = 0; l < 3; l++) send_line(1'b0);
        vsync = 1'b1; vs_cyc = cyc;
        tick(5);
        check("t5_npix", px_data.size(), 12);
        check_pix("t5_l0", 0, 16'h0001, 0, 0);
        check_pix("t5_l1", 5, 16'h0002, 1, 1);
        check_pix("t5_l2", 11, 16'h0004, 3, 2);
        check("t5_frame_done_n", fd_n, 1);
        check("t5_frame_done_latency", fd_cyc - vs_cyc, 2);
        clear_mon();
        send_line(1'b0);
        vsync = 1'b0; tick(3);
        vsync = 1'b1; tick(5);
        check("t5_vblank_href_pix", px_data.size(), 0);
        check("t5_empty_no_line_done", ld_n, 0);
        check("t5_empty_no_frame_done", fd_n, 0);

        $display("T5b vsync rises with href high");
        new_frame(2'd0);
        lb = '{8'h05, 8'hE0, 8'h06, 8'hE1};
        send_line(1'b1);
        vsync = 1'b1; vs_cyc = cyc;
        tick(5);
        href = 1'b0; tick(2);
        check("t5b_npix", px_data.size(), 2);
        check("t5b_line_done_n", ld_n, 1);
        check("t5b_frame_done_n", fd_n, 1);
        check("t5b_line_done_latency", ld_cyc - vs_cyc, 2);
        check("t5b_frame_after_line", fd_cyc - ld_cyc, 1);

        $display("T6 line length check");
        new_frame(2'd0);
        lb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        send_line(1'b0);
        lb = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        send_line(1'b0);
        check("t6_line_done_n", ld_n, 2);
        check("t6_lerr_full", (ld_lerr.size() > 0) ? ld_lerr[0] : 1'bx, 0);
`ifdef CAM_LINE_CHECK_EN
        check("t6_lerr_short", (ld_lerr.size() > 1) ? ld_lerr[1] : 1'bx, 1);
`else
        check("t6_lerr_short", (ld_lerr.size() > 1) ? ld_lerr[1] : 1'bx, 0);
`endif
        check("t6_odd_short", (ld_odd.size() > 1) ? ld_odd[1] : 1'bx, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
